// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, redirect bubbles, data-memory waits.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush performance counters on stall_cycles/flush_events.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        ifid_uses_rs2,
  input  logic        ex_redirect,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_hold,
  output logic        mem_timeout,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  // Handshake: none. Every output is a level-valid enable/flush for the current cycle;
  // pipeline registers sample them on the same rising edge that advances this FSM.

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t      r_state;
  logic [2:0]  r_flush_cnt;
  logic [7:0]  r_wait_cnt;
  logic        r_mem_timeout;

  state_t      w_state_nxt;
  logic [2:0]  w_flush_cnt_nxt;
  logic [7:0]  w_wait_inc;
  logic        w_load_use;
  logic        w_redirect_acc;
  logic        w_lu_stall;

  assign w_load_use = idex_memread && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  // Redirects and load-use are only honoured when EX is not frozen by memory.
  assign w_redirect_acc = ex_redirect && !mem_busy;
  assign w_lu_stall     = w_load_use && !mem_busy && !ex_redirect && (r_state != FLUSH);

  assign w_wait_inc = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;

  always_comb begin
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    pipe_hold       = 1'b0;
    w_state_nxt     = RUN;
    w_flush_cnt_nxt = r_flush_cnt;
    if (!rst_n) begin
      pc_write        = 1'b0;
      ifid_write      = 1'b0;
      ifid_flush      = 1'b1;
      idex_flush      = 1'b1;
      w_flush_cnt_nxt = 3'd0;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_hold   = 1'b1;
      w_state_nxt = MEM_WAIT;
    end else if (w_redirect_acc) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        w_state_nxt     = FLUSH;
        w_flush_cnt_nxt = FLUSH_LOAD;
      end
    end else if (r_state == FLUSH) begin
      // ID already holds a NOP here, so no load-use check is needed.
      ifid_flush = 1'b1;
      if (r_flush_cnt <= 3'd1) begin
        w_state_nxt     = RUN;
        w_flush_cnt_nxt = 3'd0;
      end else begin
        w_state_nxt     = FLUSH;
        w_flush_cnt_nxt = r_flush_cnt - 3'd1;
      end
    end else if (w_lu_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_flush_cnt   <= 3'd0;
      r_wait_cnt    <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if (mem_busy) begin
        r_wait_cnt <= w_wait_inc;
        if (w_wait_inc >= WAIT_LIMIT) r_mem_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= 8'd0;
      end
    end
  end

  assign mem_timeout = r_mem_timeout;
  assign state       = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
      r_flush_events <= 32'd0;
    end else begin
      if (mem_busy || w_lu_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_redirect_acc)         r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances (FLUSH_CYCLES=2 and 3) driven by shared stimulus.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        idex_memread;
  logic [4:0]  idex_rd;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        ifid_uses_rs2;
  logic        ex_redirect;
  logic        mem_busy;

  logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_flush, a_pipe_hold, a_mem_timeout;
  logic [1:0]  a_state;
  logic [31:0] a_stall_cycles, a_flush_events;
  logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush, b_pipe_hold, b_mem_timeout;
  logic [1:0]  b_state;
  logic [31:0] b_stall_cycles, b_flush_events;

  int n_tests;
  int n_fail;

  // Packed view {state, pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_timeout}
  logic [7:0] obs_a;
  logic [7:0] obs_b;
  assign obs_a = {a_state, a_pc_write, a_ifid_write, a_ifid_flush, a_idex_flush, a_pipe_hold, a_mem_timeout};
  assign obs_b = {b_state, b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush, b_pipe_hold, b_mem_timeout};

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_FL  = 2'd1;
  localparam logic [1:0] S_MW  = 2'd2;
  localparam logic [5:0] O_RST   = 6'b001100;
  localparam logic [5:0] O_NORM  = 6'b110000;
  localparam logic [5:0] O_LU    = 6'b000100;
  localparam logic [5:0] O_REDIR = 6'b111100;
  localparam logic [5:0] O_FLUSH = 6'b111000;
  localparam logic [5:0] O_BUSY  = 6'b000010;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MAX_WAIT(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
    .idex_flush(a_idex_flush), .pipe_hold(a_pipe_hold), .mem_timeout(a_mem_timeout),
    .state(a_state), .stall_cycles(a_stall_cycles), .flush_events(a_flush_events)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .MAX_WAIT(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
    .idex_flush(b_idex_flush), .pipe_hold(b_pipe_hold), .mem_timeout(b_mem_timeout),
    .state(b_state), .stall_cycles(b_stall_cycles), .flush_events(b_flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic cyc(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic u2, input logic redir, input logic busy);
    @(negedge clk);
    idex_memread  = mr;
    idex_rd       = rd;
    ifid_rs1      = rs1;
    ifid_rs2      = rs2;
    ifid_uses_rs2 = u2;
    ex_redirect   = redir;
    mem_busy      = busy;
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    idex_memread = 1'b0; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
    ifid_uses_rs2 = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;
    #2;
    chk("reset_a", obs_a, {S_RUN, O_RST});
    chk("reset_b", obs_b, {S_RUN, O_RST});
    @(negedge clk);
    rst_n = 1'b1;

    idle();                                             chk("idle", obs_a, {S_RUN, O_NORM});
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);      chk("lu_rs1", obs_a, {S_RUN, O_LU});
    cyc(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);      chk("lu_rs1_after", obs_a, {S_RUN, O_NORM});
    cyc(1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);      chk("lu_rs2", obs_a, {S_RUN, O_LU});
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);      chk("rd_zero", obs_a, {S_RUN, O_NORM});
    cyc(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);      chk("rs2_unused", obs_a, {S_RUN, O_NORM});
    cyc(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);      chk("no_memread", obs_a, {S_RUN, O_NORM});

    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);      chk("redir_t", obs_a, {S_RUN, O_REDIR});
    idle();                                             chk("redir_t1", obs_a, {S_FL, O_FLUSH});
    idle();                                             chk("redir_t2", obs_a, {S_FL, O_FLUSH});
    idle();                                             chk("redir_t3", obs_a, {S_RUN, O_NORM});

    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);      chk("prio_b1", obs_a, {S_RUN, O_BUSY});
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);      chk("prio_b2", obs_a, {S_MW, O_BUSY});
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);      chk("prio_b3", obs_a, {S_MW, O_BUSY});
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);      chk("prio_exit", obs_a, {S_MW, O_REDIR});
    idle();                                             chk("prio_fl1", obs_a, {S_FL, O_FLUSH});
    idle();                                             chk("prio_fl2", obs_a, {S_FL, O_FLUSH});
    idle();                                             chk("prio_run", obs_a, {S_RUN, O_NORM});

    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);      chk("reload_t", obs_a, {S_RUN, O_REDIR});
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);      chk("reload_again", obs_a, {S_FL, O_REDIR});
    cyc(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);      chk("lu_in_flush", obs_a, {S_FL, O_FLUSH});
    idle();                                             chk("reload_fl2", obs_a, {S_FL, O_FLUSH});
    idle();                                             chk("reload_run", obs_a, {S_RUN, O_NORM});
    repeat (3) idle();
    chk("settle_b", obs_b, {S_RUN, O_NORM});

    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("tmo_busy%0d", k), obs_a,
          {(k == 1) ? S_RUN : S_MW, 5'b00001, (k > 16) ? 1'b1 : 1'b0});
    end
    idle();                                             chk("tmo_drop", obs_a, {S_MW, 6'b110001});
    idle();                                             chk("tmo_sticky", obs_a, {S_RUN, 6'b110001});

    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);      chk("rstfl_t", obs_b, {S_RUN, 6'b111101});
    idle();                                             chk("rstfl_f1", obs_b, {S_FL, 6'b111001});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstfl_async_b", obs_b, {S_RUN, O_RST});
    chk("rstfl_async_a", obs_a, {S_RUN, O_RST});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstfl_release", obs_b, {S_RUN, O_NORM});
    idle();                                             chk("rstfl_run_b", obs_b, {S_RUN, O_NORM});
    chk("rstfl_run_a", obs_a, {S_RUN, O_NORM});

`ifndef HAZARD_PERF_CNT_EN
    chk("perf_tied", {7'd0, |{a_stall_cycles, a_flush_events}}, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Generates PC write-enable, IF/ID write/flush, ID/EX flush and whole-pipe hold.
- Handles three cases: load-use stalls, branch/JALR redirect bubbles, and multi-cycle data-memory waits.
- Sits beside the IF/ID and ID/EX pipeline registers; all control to them originates here.

Parameters:
- FLUSH_CYCLES, 1: extra cycles IF/ID stays flushed after a redirect (instruction-memory read latency); legal 0..7.
- MAX_WAIT, 16: consecutive mem_busy cycles tolerated before mem_timeout sets; legal 1..255.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- idex_memread  in  1  instruction in EX is a load.
- idex_rd  in  5  destination register of the instruction in EX.
- ifid_rs1  in  5  rs1 of the instruction in ID.
- ifid_rs2  in  5  rs2 of the instruction in ID.
- ifid_uses_rs2  in  1  instruction in ID reads rs2 (R/S/B type).
- ex_redirect  in  1  branch taken or JALR resolved in EX this cycle.
- mem_busy  in  1  data memory not ready; MEM stage must hold.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX loads all-zero controls (bubble).
- pipe_hold  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- mem_timeout  out  1  sticky: mem_busy exceeded MAX_WAIT.
- state  out  2  FSM state, for debug.

Behaviour:
- FSM states: RUN=0, FLUSH=1, MEM_WAIT=2. Encoding 3 is illegal and returns to RUN.
- State, counters and mem_timeout are registered. Stall/flush outputs are combinational from state and inputs (zero latency).
- While rst_n=0: state=RUN, pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_hold=0, mem_timeout=0, all counters cleared. Reset applies asynchronously, including mid-FLUSH or mid-MEM_WAIT.
- Priority each cycle: mem_busy > ex_redirect > load-use > normal.
- mem_busy=1 (any state):
  - Outputs: pc_write=0, ifid_write=0, pipe_hold=1; both flushes 0.
  - Next state MEM_WAIT; wait_cnt increments, saturating at 255.
  - A concurrent ex_redirect or load-use is ignored. EX is frozen, so it is re-presented when mem_busy drops.
- MEM_WAIT with mem_busy=0: clear wait_cnt, then evaluate redirect/load-use as in RUN. Next state RUN, or FLUSH if a redirect occurs.
- mem_timeout sets on the cycle wait_cnt reaches MAX_WAIT while mem_busy=1. It clears only on reset.
- ex_redirect=1 with mem_busy=0:
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1.
  - If FLUSH_CYCLES>0: next state FLUSH, flush_cnt=FLUSH_CYCLES. Otherwise stay in RUN.
- FLUSH state:
  - Outputs: ifid_flush=1, pc_write=1, ifid_write=1, idex_flush=0.
  - flush_cnt decrements each cycle; exit to RUN when it reaches 1.
  - A new ex_redirect in FLUSH reloads flush_cnt and asserts idex_flush that cycle.
  - Load-use detection is suppressed in FLUSH (ID holds a NOP).
- Load-use hazard, evaluated in RUN (and the MEM_WAIT exit cycle):
  - Condition: idex_memread & idex_rd!=0 & (idex_rd==ifid_rs1 | (ifid_uses_rs2 & idex_rd==ifid_rs2)).
  - Outputs: pc_write=0, ifid_write=0, idex_flush=1 for exactly that cycle. State stays RUN.
  - The bubble removes the condition on the next cycle.
- Normal operation: pc_write=1, ifid_write=1, all flushes and pipe_hold 0.
- idex_rd=0 never creates a hazard.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cycles [31:0] (load-use + MEM_WAIT cycles) and flush_events [31:0] (accepted redirects).
  - Both are wrapping counters, cleared by reset.
- When undefined: the ports still exist but are tied to 0, and no counter flops are built.

Test Plan:
- Load-use on rs1: idex_memread=1, idex_rd=5, ifid_rs1=5 for one cycle -> that cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle (rd cleared) all normal.
- No false hazard: idex_rd=0 = ifid_rs1=0 with memread=1, and rs2 match with ifid_uses_rs2=0 -> pc_write=1, no flush.
- Redirect, FLUSH_CYCLES=2: ex_redirect pulse at cycle t:
  - t: ifid_flush=idex_flush=1.
  - t+1, t+2: ifid_flush=1 only, state=FLUSH.
  - t+3: RUN, all flushes 0.
- Priority: mem_busy=1 for 3 cycles with concurrent ex_redirect and load-use:
  - 3 cycles: pipe_hold=1, pc_write=0, no flush.
  - Cycle 4 (mem_busy=0): redirect flush occurs.
- Timeout, MAX_WAIT=16: mem_busy held 20 cycles -> mem_timeout rises after 16th busy cycle, stays 1 after busy drops until rst_n pulse.
- Reset mid-FLUSH with FLUSH_CYCLES=3: rst_n low in 2nd flush cycle -> immediately state=RUN and reset output values; after release, normal RUN outputs.
